avalon_mem_responder: RTL and testbench



---
 rtl/avalon_mem_responder_if.sv | 43 ++++
 rtl/avalon_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_avalon_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM bus bundle between a CPU-side master and a memory responder.
//
// Signals:
//   address     byte address from the master (bits [1:0] ignored by the responder)
//   read        read request
//   write       write request
//   writedata   store data
//   byteenable  byte lane enables; bit i selects writedata[8i+7:8i]
//   waitrequest high while the transfer has not been accepted
//   readdata    read data, valid in the accept cycle of a read
//
// Modports:
//   master  drives the request side, observes waitrequest/readdata
//   slave   observes the request side, drives waitrequest/readdata
interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// Avalon-MM responder backed by a word-addressed RAM window.
//
// Each transfer is latched when first requested, held for a number of wait
// states, then accepted for exactly one cycle (waitrequest low). Reads return
// the addressed word (or zero outside the window); writes commit on the
// accept edge with per-byte enables. Master misbehaviour is flagged on a
// sticky protocol_err output.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   bus           avalon_mem_responder_if.slave (request/response bundle)
//   protocol_err  sticky flag: master changed or dropped a request mid-transfer,
//                 or asserted read and write together; cleared only by reset
//
// Parameters:
//   ADDR_W       log2 of memory depth in 32-bit words
//   BASE_ADDR    byte address of word 0, aligned to 4*2^ADDR_W
//   WAIT_CYCLES  wait states per transfer, 1..15
//
// Build option:
//   AVALON_MEM_RANDOM_WAIT_EN  when defined, each transfer uses
//                              1 + (lfsr[3:0] % WAIT_CYCLES) wait states from a
//                              16-bit LFSR advanced once per accepted transfer.
module avalon_mem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    avalon_mem_responder_if.slave         bus,
    output logic                          protocol_err
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] wait_load;

    // Transfer context captured at request start.
    logic [31:0]       lat_addr_q;
    logic              lat_read_q;      // raw request bits, for protocol checks
    logic              lat_write_q;
    logic              lat_do_write_q;  // write is dropped when read is also set
    logic [31:0]       lat_wdata_q;
    logic [3:0]        lat_be_q;
    logic              lat_hit_q;
    logic [ADDR_W-1:0] lat_idx_q;

    logic [31:0] readdata_q;
    logic        protocol_err_q, protocol_err_d;

    logic [31:0] mem [Depth];

    logic req;
    logic hit;
    logic start;
    logic load_rd;
    logic commit;
    logic accept;
    logic mismatch;

    assign req = bus.read | bus.write;
    assign hit = (bus.address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    assign bus.waitrequest = reset | (req & (state_q != StAck));
    assign bus.readdata    = readdata_q;
    assign protocol_err    = protocol_err_q;

    // Any deviation from the latched request while the transfer is in flight.
    assign mismatch = (bus.read != lat_read_q) | (bus.write != lat_write_q) |
                      (bus.address != lat_addr_q);

`ifdef AVALON_MEM_RANDOM_WAIT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Taps 16,14,13,11 in right-shift Fibonacci form.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else if (accept) begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end

    // Counter holds (wait count - 1), so the +1 of the wait count cancels.
    assign wait_load = 4'(32'(lfsr_q[3:0]) % WAIT_CYCLES);
`else
    assign wait_load = 4'(WAIT_CYCLES - 1);
`endif

    // Next-state and transfer control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        load_rd = 1'b0;
        commit  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    start   = 1'b1;
                    cnt_d   = wait_load;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    load_rd = lat_read_q;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                accept  = 1'b1;
                // A write dropped by the master in the accept cycle is not committed.
                commit  = lat_do_write_q & bus.write & lat_hit_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        protocol_err_d = protocol_err_q;
        if (start && bus.read && bus.write) begin
            protocol_err_d = 1'b1;
        end
        if ((state_q == StWait || state_q == StAck) && mismatch) begin
            protocol_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            readdata_q     <= 32'h0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            protocol_err_q <= protocol_err_d;
            if (load_rd) begin
                readdata_q <= lat_hit_q ? mem[lat_idx_q] : 32'h0;
            end
        end
    end

    // Context registers need no reset: they are only consumed after a start.
    always_ff @(posedge clk) begin
        if (start) begin
            lat_addr_q     <= bus.address;
            lat_read_q     <= bus.read;
            lat_write_q    <= bus.write;
            lat_do_write_q <= bus.write & ~bus.read;
            lat_wdata_q    <= bus.writedata;
            lat_be_q       <= bus.byteenable;
            lat_hit_q      <= hit;
            lat_idx_q      <= bus.address[ADDR_W+1:2];
        end
    end

    // Memory contents survive reset; a write pending at reset is simply lost.
    always_ff @(posedge clk) begin
        if (commit && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be_q[b]) begin
                    mem[lat_idx_q][8*b +: 8] <= lat_wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: a WAIT_CYCLES=1 instance for the main
// function and a WAIT_CYCLES=3 instance for back-to-back timing. Requests go
// to the instance chosen by sel; expected read data is queued when a read is
// driven and compared when the transfer is accepted.
module tb_avalon_mem_responder;

    logic clk;
    logic reset;
    logic sel;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    logic perr1, perr3;
    logic wq;
    logic [31:0] rdq;
    logic perr;

    avalon_mem_responder_if bus1 ();
    avalon_mem_responder_if bus3 ();

    assign bus1.address    = address;
    assign bus1.writedata  = writedata;
    assign bus1.byteenable = byteenable;
    assign bus1.read       = read & ~sel;
    assign bus1.write      = write & ~sel;

    assign bus3.address    = address;
    assign bus3.writedata  = writedata;
    assign bus3.byteenable = byteenable;
    assign bus3.read       = read & sel;
    assign bus3.write      = write & sel;

    assign wq   = sel ? bus3.waitrequest : bus1.waitrequest;
    assign rdq  = sel ? bus3.readdata : bus1.readdata;
    assign perr = sel ? perr3 : perr1;

    avalon_mem_responder #(
        .WAIT_CYCLES(1)
    ) u_dut1 (
        .clk(clk),
        .reset(reset),
        .bus(bus1),
        .protocol_err(perr1)
    );

    avalon_mem_responder #(
        .WAIT_CYCLES(3)
    ) u_dut3 (
        .clk(clk),
        .reset(reset),
        .bus(bus3),
        .protocol_err(perr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model [2][1024];
    logic [31:0] last_rd [2];
    bit          exp_w [10];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends
    // the accept cycle, with the request deasserted.
    task automatic bus_xfer(input string tag, input logic [31:0] a, input logic rd,
                            input logic wr, input logic [31:0] d, input logic [3:0] be);
        int          lat;
        bit          done;
        int          s;
        int unsigned idx;
        bit          hit;
        logic [31:0] cur;
        s   = sel ? 1 : 0;
        idx = 32'(a[11:2]);
        hit = (a[31:12] == 20'hBFC00);
        if (rd) exp_q.push_back(hit ? model[s][idx] : 32'h0);
        address    = a;
        read       = rd;
        write      = wr;
        writedata  = d;
        byteenable = be;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            if (wq) begin
                lat++;
            end else begin
                done = 1'b1;
                if (rd) begin
                    cur = exp_q.pop_front();
                    check_eq({tag, "_rdata"}, rdq, cur);
                    last_rd[s] = cur;
                end else begin
                    check_eq({tag, "_hold"}, rdq, last_rd[s]);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done && rd) void'(exp_q.pop_front());
        read  = 1'b0;
        write = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), sel ? 32'd4 : 32'd2);
        if (wr && !rd && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[s][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    initial begin
        sel        = 1'b0;
        address    = 32'h0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        reset      = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_waitreq", 32'(wq), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_waitreq", 32'(wq), 32'd0);
        check_eq("rst_rdata", rdq, 32'h0);
        check_eq("rst_perr1", 32'(perr1), 32'd0);
        check_eq("rst_perr3", 32'(perr3), 32'd0);
        @(posedge clk);
        #1;

        // Full-word write and read-back.
        bus_xfer("wr_dead", 32'hBFC00010, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF);
        bus_xfer("rd_dead", 32'hBFC00010, 1'b1, 1'b0, 32'h0, 4'h0);

        // Byte-enabled write: lanes 0 and 2 only.
        bus_xfer("pre_1122", 32'hBFC00020, 1'b0, 1'b1, 32'h11223344, 4'hF);
        bus_xfer("wr_be5", 32'hBFC00020, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101);
        bus_xfer("rd_be5", 32'hBFC00020, 1'b1, 1'b0, 32'h0, 4'h0);
        check_eq("be5_value", last_rd[0], 32'h11BB33DD);

        // Misses: read returns zero, write is dropped.
        bus_xfer("pre_5566", 32'hBFC00004, 1'b0, 1'b1, 32'h55667788, 4'hF);
        bus_xfer("rd_miss", 32'h00000000, 1'b1, 1'b0, 32'h0, 4'h0);
        bus_xfer("wr_miss", 32'h00000004, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF);
        bus_xfer("rd_aftmiss", 32'hBFC00004, 1'b1, 1'b0, 32'h0, 4'h0);
        check_eq("perr_clean", 32'(perr), 32'd0);

        // Read and write together: read wins, write dropped, sticky error.
        bus_xfer("pre_0bad", 32'hBFC00000, 1'b0, 1'b1, 32'h0BADF00D, 4'hF);
        bus_xfer("rdwr", 32'hBFC00000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF);
        check_eq("rdwr_perr", 32'(perr), 32'd1);
        bus_xfer("rd_aftrdwr", 32'hBFC00000, 1'b1, 1'b0, 32'h0, 4'h0);
        check_eq("perr_sticky", 32'(perr), 32'd1);

        // Back-to-back reads on the WAIT_CYCLES=3 instance.
        sel = 1'b1;
        bus_xfer("w3_0", 32'hBFC00000, 1'b0, 1'b1, 32'hA0A0A0A0, 4'hF);
        bus_xfer("w3_1", 32'hBFC00004, 1'b0, 1'b1, 32'hB1B1B1B1, 4'hF);
        exp_q.push_back(model[1][0]);
        exp_q.push_back(model[1][1]);
        address = 32'hBFC00000;
        read    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("b2b_waitreq%0d", i), 32'(wq), 32'(exp_w[i]));
            if (!wq && exp_q.size() > 0) check_eq($sformatf("b2b_rdata%0d", i), rdq, exp_q.pop_front());
            @(posedge clk);
            #1;
            if (i == 4) address = 32'hBFC00004;
        end
        read = 1'b0;
        check_eq("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("b2b_perr", 32'(perr), 32'd0);
        sel = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the wait state of a write.
        address    = 32'hBFC00010;
        write      = 1'b1;
        writedata  = 32'h12345678;
        byteenable = 4'hF;
        @(negedge clk);
        check_eq("rstmid_req", 32'(wq), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rstmid_waitreq", 32'(wq), 32'd1);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        write      = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        check_eq("rstmid_idle", 32'(wq), 32'd0);
        check_eq("rstmid_perr", 32'(perr1), 32'd0);
        check_eq("rstmid_rdata", rdq, 32'h0);
        @(posedge clk);
        #1;
        bus_xfer("rd_aftrst", 32'hBFC00010, 1'b1, 1'b0, 32'h0, 4'h0);
        check_eq("aftrst_value", last_rd[0], 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
